// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree with valid/ready flow control; one register stage per tree level.
// Define MUX_TREE_PIPE_SCAN_EN to include the auto-scan channel sequencer driven by scan_en.
module mux_tree_pipe #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(2**SEL_W)*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]              in_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          scan_en,
  output logic [WIDTH-1:0]              out_data,
  output logic [SEL_W-1:0]              out_chan,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int N = 2**SEL_W;

  logic             stall;
  logic             advance;
  logic             accept;
  logic [SEL_W-1:0] esel;

  // One global stall: every stage freezes together, so bubbles are never squeezed out.
  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

`ifdef MUX_TREE_PIPE_SCAN_EN
  logic [SEL_W-1:0] scanCnt_q;
  logic [SEL_W-1:0] scanCnt_d;

  // N is a power of two, so the natural wrap of the counter gives N-1 -> 0.
  always_comb begin
    scanCnt_d = scanCnt_q;
    if (accept && scan_en) begin
      scanCnt_d = scanCnt_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scanCnt_q <= '0;
    end else begin
      scanCnt_q <= scanCnt_d;
    end
  end

  assign esel = scan_en ? scanCnt_q : in_sel;
`else
  logic unusedScanEn;

  assign unusedScanEn = scan_en;
  assign esel         = in_sel;
`endif

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int M = N >> (k + 1);

    logic [2*M*WIDTH-1:0] src;
    logic [SEL_W-1:0]     selIn;
    logic                 validIn;
    logic [M*WIDTH-1:0]   data_d;
    logic [M*WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]     sel_q;
    logic                 valid_q;

    if (k == 0) begin : g_head
      assign src     = in_data;
      assign selIn   = esel;
      assign validIn = accept;
    end else begin : g_body
      assign src     = g_lvl[k-1].data_q;
      assign selIn   = g_lvl[k-1].sel_q;
      assign validIn = g_lvl[k-1].valid_q;
    end

    // Level k resolves select bit k, pairing entries (2j, 2j+1) of the previous level.
    always_comb begin
      data_d = '0;
      for (int j = 0; j < M; j++) begin
        data_d[j*WIDTH +: WIDTH] = selIn[k] ? src[(2*j+1)*WIDTH +: WIDTH]
                                            : src[(2*j)*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        sel_q   <= '0;
      end else if (advance) begin
        valid_q <= validIn;
        data_q  <= data_d;
        sel_q   <= selIn;
      end
    end
  end

  assign out_data  = g_lvl[SEL_W-1].data_q;
  assign out_chan  = g_lvl[SEL_W-1].sel_q;
  assign out_valid = g_lvl[SEL_W-1].valid_q;

endmodule
